// File: rtl/vector_alu_seq.sv
// rtl/vector_alu_seq.sv - lane-serial saturating element-wise vector ALU
module vector_alu_seq #(
    parameter int W     = 32,
    parameter int N     = 6,
    parameter int FRAC  = 16,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [$clog2(N+1)-1:0]   length,
    input  logic [N*W-1:0]           Ain,
    input  logic [N*W-1:0]           Bin,
    output logic                     busy,
    output logic                     done,
    output logic                     sat,
    output logic [N*W-1:0]           Cout
);
    localparam int LW = $clog2(N+1);
    localparam int IW = $clog2(N+LANES+1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;
    state_t state, next_state;

    logic signed [W-1:0]   a_reg [N];
    logic signed [W-1:0]   b_reg [N];
    logic signed [W-1:0]   res   [N];
    logic signed [W-1:0]   nres  [N];
    logic [1:0]            op_reg;
    logic [LW-1:0]         len_reg;
    logic [IW-1:0]         idx;
    logic                  sat_acc;
    logic                  nsat;
    logic                  last;

    logic [IW-1:0]         lane_idx [LANES];
    logic                  lane_ok  [LANES];
    logic signed [W-1:0]   lane_res [LANES];
    logic                  lane_sat [LANES];
    logic signed [W-1:0]   op_a, op_b;
    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   wide;

    // Each lane evaluates at 2W+1 bits so one clamp stage covers add, sub and products.
    always_comb begin
        op_a = '0;
        op_b = '0;
        prod = '0;
        wide = '0;
        nres = res;
        nsat = sat_acc;
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = idx + IW'(j);
            lane_ok[j]  = int'(lane_idx[j]) < N;
            lane_res[j] = '0;
            lane_sat[j] = 1'b0;
            if (int'(lane_idx[j]) < int'(len_reg)) begin
                op_a = a_reg[lane_idx[j][AW-1:0]];
                op_b = (op_reg == 2'b11) ? b_reg[0] : b_reg[lane_idx[j][AW-1:0]];
                case (op_reg)
                    2'b00:   wide = (2*W+1)'(op_a) + (2*W+1)'(op_b);
                    2'b01:   wide = (2*W+1)'(op_a) - (2*W+1)'(op_b);
                    default: begin
                        prod = op_a * op_b;
                        wide = (2*W+1)'(prod >>> FRAC);
                    end
                endcase
                if (wide > MAXV) begin
                    lane_res[j] = MAXV[W-1:0];
                    lane_sat[j] = 1'b1;
                end else if (wide < MINV) begin
                    lane_res[j] = MINV[W-1:0];
                    lane_sat[j] = 1'b1;
                end else begin
                    lane_res[j] = wide[W-1:0];
                end
            end
            if (lane_ok[j]) begin
                nres[lane_idx[j][AW-1:0]] = lane_res[j];
                nsat = nsat | lane_sat[j];
            end
        end
    end

    assign last = (int'(idx) + LANES) >= N;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:    if (start) next_state = S_COMPUTE;
            S_COMPUTE: begin
                busy = 1'b1;
                if (last) next_state = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
                res[i]   <= '0;
            end
            op_reg  <= '0;
            len_reg <= '0;
            idx     <= '0;
            sat_acc <= 1'b0;
            sat     <= 1'b0;
            Cout    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    for (int i = 0; i < N; i++) begin
                        a_reg[i] <= Ain[i*W +: W];
                        b_reg[i] <= Bin[i*W +: W];
                    end
                    op_reg  <= op;
                    len_reg <= (int'(length) > N) ? LW'(N) : length;
                    idx     <= '0;
                    sat_acc <= 1'b0;
                end
                S_COMPUTE: begin
                    res     <= nres;
                    sat_acc <= nsat;
                    idx     <= idx + IW'(LANES);
                    // Outputs take the final lanes directly so they are valid in the DONE cycle.
                    if (last) begin
                        for (int i = 0; i < N; i++) Cout[i*W +: W] <= nres[i];
                        sat <= nsat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_alu_seq.sv
// tb/tb_vector_alu_seq.sv - directed self-checking bench for vector_alu_seq
module tb_vector_alu_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [2:0]   length;
    logic [191:0] ain, bin;
    logic         busy, done, sat;
    logic [191:0] cout;
    int           pass_cnt = 0;
    int           total = 0;
    logic [31:0]  exp_c [6];

    vector_alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .length(length),
        .Ain(ain), .Bin(bin), .busy(busy), .done(done), .sat(sat), .Cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] el(input int i);
        return cout[i*32 +: 32];
    endfunction

    task automatic put(input int i, input logic [31:0] a, input logic [31:0] b);
        ain[i*32 +: 32] = a;
        bin[i*32 +: 32] = b;
    endtask

    task automatic run(input logic [1:0] o, input logic [2:0] len, output int lat, output int bcnt);
        @(negedge clk);
        op = o; length = len; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 1; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; length = 3'd0; ain = '0; bin = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total++; if (sat !== 1'b0) $display("FAIL reset_sat got %b want 0", sat); else pass_cnt++;
        total++; if (cout !== '0) $display("FAIL reset_cout got %h want 0", cout); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, bcnt;
        for (int i = 0; i < 6; i++) put(i, 32'(i + 1), 32'(10 * (i + 1)));
        run(2'b00, 3'd6, lat, bcnt);
        total++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else pass_cnt++;
        total++; if (bcnt !== 4) $display("FAIL add_busy_cycles got %0d want 4", bcnt); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (el(i) !== 32'(11 * (i + 1))) $display("FAIL add_c%0d got %0d want %0d", i, el(i), 11 * (i + 1));
            else pass_cnt++;
        end
        total++; if (sat !== 1'b0) $display("FAIL add_sat got %b want 0", sat); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0 || el(0) !== 32'd11) $display("FAIL add_hold got done=%b c0=%0d want 0/11", done, el(0)); else pass_cnt++;
    endtask

    task automatic test_sub();
        int lat, bcnt;
        for (int i = 0; i < 6; i++) put(i, 32'd5, 32'd7);
        run(2'b01, 3'd4, lat, bcnt);
        exp_c = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            total++; if (el(i) !== exp_c[i]) $display("FAIL sub_len4_c%0d got %h want %h", i, el(i), exp_c[i]); else pass_cnt++;
        end
        total++; if (sat !== 1'b0) $display("FAIL sub_sat got %b want 0", sat); else pass_cnt++;
        run(2'b01, 3'd7, lat, bcnt);
        for (int i = 0; i < 6; i++) begin
            total++; if (el(i) !== 32'hFFFFFFFE) $display("FAIL sub_clamp_c%0d got %h want fffffffe", i, el(i)); else pass_cnt++;
        end
    endtask

    task automatic test_sat_add();
        int lat, bcnt;
        ain = '0; bin = '0;
        put(0, 32'h7FFFFFFF, 32'h1);
        put(1, 32'h80000000, 32'hFFFFFFFF);
        run(2'b00, 3'd6, lat, bcnt);
        total++; if (el(0) !== 32'h7FFFFFFF) $display("FAIL satadd_c0 got %h want 7fffffff", el(0)); else pass_cnt++;
        total++; if (el(1) !== 32'h80000000) $display("FAIL satadd_c1 got %h want 80000000", el(1)); else pass_cnt++;
        total++; if (sat !== 1'b1) $display("FAIL satadd_sat got %b want 1", sat); else pass_cnt++;
        ain = '0; bin = '0;
        put(5, 32'h7FFFFFFF, 32'h1);
        run(2'b00, 3'd5, lat, bcnt);
        total++; if (el(5) !== 32'h0) $display("FAIL inactive_c5 got %h want 0", el(5)); else pass_cnt++;
        total++; if (sat !== 1'b0) $display("FAIL inactive_sat got %b want 0", sat); else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat, bcnt;
        ain = '0; bin = '0;
        put(0, 32'h00018000, 32'hFFFE0000);
        put(1, 32'h7FFF0000, 32'h00020000);
        run(2'b10, 3'd2, lat, bcnt);
        total++; if (el(0) !== 32'hFFFD0000) $display("FAIL mul_c0 got %h want fffd0000", el(0)); else pass_cnt++;
        total++; if (el(1) !== 32'h7FFFFFFF) $display("FAIL mul_c1 got %h want 7fffffff", el(1)); else pass_cnt++;
        total++; if (el(2) !== 32'h0) $display("FAIL mul_c2 got %h want 0", el(2)); else pass_cnt++;
        total++; if (sat !== 1'b1) $display("FAIL mul_sat got %b want 1", sat); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, dcnt;
        for (int i = 0; i < 6; i++) put(i, 32'(i + 1), 32'(10 * (i + 1)));
        @(negedge clk);
        op = 2'b00; length = 3'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else pass_cnt++;
        total++; if (sat !== 1'b0) $display("FAIL midrst_sat got %b want 0", sat); else pass_cnt++;
        total++; if (cout !== '0) $display("FAIL midrst_cout got %h want 0", cout); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        total++; if (dcnt !== 0) $display("FAIL midrst_no_done got %0d want 0", dcnt); else pass_cnt++;
        run(2'b00, 3'd6, lat, bcnt);
        total++; if (lat !== 4) $display("FAIL postrst_latency got %0d want 4", lat); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total++; if (el(i) !== 32'(11 * (i + 1))) $display("FAIL postrst_c%0d got %0d want %0d", i, el(i), 11 * (i + 1)); else pass_cnt++;
        end
    endtask

    task automatic test_scale();
        int lat, bcnt;
        for (int i = 0; i < 6; i++) put(i, 32'h00020000, 32'hDEAD0000);
        bin[31:0] = 32'h00008000;
        run(2'b11, 3'd6, lat, bcnt);
        for (int i = 0; i < 6; i++) begin
            total++; if (el(i) !== 32'h00010000) $display("FAIL scale_c%0d got %h want 00010000", i, el(i)); else pass_cnt++;
        end
        total++; if (sat !== 1'b0) $display("FAIL scale_sat got %b want 0", sat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d1, d2, dcnt;
        for (int i = 0; i < 6; i++) put(i, 32'(i + 1), 32'd0);
        d1 = 0; d2 = 0; dcnt = 0;
        @(negedge clk);
        op = 2'b00; length = 3'd6; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) for (int i = 0; i < 6; i++) ain[i*32 +: 32] = 32'd100;
            if (c == 10) start = 1'b0;
            if (done) begin
                dcnt++;
                if (d1 == 0) begin
                    d1 = c;
                    total++; if (el(5) !== 32'd6) $display("FAIL b2b_first_c5 got %0d want 6", el(5)); else pass_cnt++;
                end else begin
                    d2 = c;
                    total++; if (el(5) !== 32'd100) $display("FAIL b2b_second_c5 got %0d want 100", el(5)); else pass_cnt++;
                end
            end
        end
        total++; if (d1 !== 4) $display("FAIL b2b_first_done got cycle %0d want 4", d1); else pass_cnt++;
        total++; if (d2 !== 9) $display("FAIL b2b_second_done got cycle %0d want 9", d2); else pass_cnt++;
        total++; if (dcnt !== 2) $display("FAIL b2b_done_count got %0d want 2", dcnt); else pass_cnt++;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_sat_add();
        test_mul();
        test_reset_mid();
        test_scale();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
